// File: rtl/mem_access_cycle_pkg.sv
// Shared encodings for the MEM stage: funct3 load/store sizes, ResultSrc
// selects, the bus FSM state type and a size-decode helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    // Access size from funct3; BU/HU only exist for loads, every undefined
    // encoding falls back to a full word.
    function automatic acc_size_t decode_size(input logic [2:0] f3, input logic is_store);
        acc_size_t sz;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_BU:   sz = is_store ? SZ_W : SZ_B;
            F3_HU:   sz = is_store ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_cycle_lsu_align.sv
// lsu_align: purely combinational lane logic for the MEM stage.
// Produces store byte-enables and lane-replicated write data, and
// extracts/extends load data from the addressed lane.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata_ext
);

    acc_size_t   w_size;
    logic        w_signed;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;

    assign w_size      = decode_size(i_funct3, i_is_store);
    assign w_signed    = ~i_funct3[2];
    assign w_lane_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_lane_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Byte-enable pattern shifted to the addressed lane(s).
    always_comb begin
        o_be = 4'b1111;
        case (w_size)
            SZ_B:    o_be = 4'b0001 << i_addr_lo;
            SZ_H:    o_be = 4'b0011 << {i_addr_lo[1], 1'b0};
            default: o_be = 4'b1111;
        endcase
    end

    // Each byte lane carries the byte/half/word source so any aligned
    // position sees the right data; the enables pick the live lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            localparam int HALF_LO = (gi % 2) * 8;
            assign o_wdata[gi*8 +: 8] = (w_size == SZ_B) ? i_wdata[7:0] :
                                        (w_size == SZ_H) ? i_wdata[HALF_LO +: 8] :
                                                           i_wdata[gi*8 +: 8];
        end
    endgenerate

    // Load data: select lane, then sign- or zero-extend.
    always_comb begin
        o_rdata_ext = i_rdata;
        case (w_size)
            SZ_B:    o_rdata_ext = {{24{w_signed & w_lane_byte[7]}}, w_lane_byte};
            SZ_H:    o_rdata_ext = {{16{w_signed & w_lane_half[15]}}, w_lane_half};
            default: o_rdata_ext = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_cycle.sv
// mem_access_cycle: MEM stage of the RV32I pipeline. Runs the req/gnt/rvalid
// data-memory handshake, stalls upstream while an access is outstanding and
// holds the MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the
// bus and retire immediately with MisalignW=1 and no register write.
module mem_access_cycle
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        funct3M,
    input  logic [REG_AW-1:0] RDM,
    input  logic [XLEN-1:0]   ALU_ResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [XLEN-1:0]   PCPlus4M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              StallM,
    output logic              ValidW,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              MisalignW,
`endif
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [REG_AW-1:0] RDW,
    output logic [XLEN-1:0]   ALU_ResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   PCPlus4W
);

    mem_state_t      r_state;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_misalign;
    logic            w_mem_op;
    logic            w_complete;
    logic [XLEN-1:0] w_rdata_ext;

    assign w_is_store = MemWriteM;
    assign w_is_load  = (ResultSrcM == RES_MEM) & ~MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
    acc_size_t w_size;
    assign w_size     = decode_size(funct3M, MemWriteM);
    assign w_misalign = ValidM & (w_is_load | w_is_store) &
                        (((w_size == SZ_H) & ALU_ResultM[0]) |
                         ((w_size == SZ_W) & (ALU_ResultM[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // A real load/store that actually needs the bus.
    assign w_mem_op = ValidM & (w_is_load | w_is_store) & ~w_misalign;

    assign dmem_req  = ((r_state == IDLE) & w_mem_op) | (r_state == REQ);
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALU_ResultM[XLEN-1:2], 2'b00};

    // Stores finish on gnt; loads only on rvalid in RESP, so rvalid in the
    // gnt cycle or in IDLE (stray, after reset) never completes anything.
    assign w_complete = (w_is_store & dmem_req & dmem_gnt) |
                        (w_is_load & (r_state == RESP) & dmem_rvalid);

    assign StallM = w_mem_op & ~w_complete;

    lsu_align u_lsu_align (
        .i_funct3    (funct3M),
        .i_is_store  (MemWriteM),
        .i_addr_lo   (ALU_ResultM[1:0]),
        .i_wdata     (WriteDataM),
        .i_rdata     (dmem_rdata),
        .o_be        (dmem_be),
        .o_wdata     (dmem_wdata),
        .o_rdata_ext (w_rdata_ext)
    );

    // Bus handshake FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        if (dmem_gnt) r_state <= w_is_load ? RESP : IDLE;
                        else          r_state <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) r_state <= w_is_load ? RESP : IDLE;
                end
                RESP: begin
                    if (dmem_rvalid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // MEM/WB register: capture when not stalled, otherwise emit a bubble.
    // The trap flag is cleared on bubbles so it only ever accompanies ValidW.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RDW         <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            PCPlus4W    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            MisalignW   <= 1'b0;
`endif
        end else if (!StallM) begin
            ValidW      <= ValidM;
            RegWriteW   <= ValidM & RegWriteM & ~w_misalign;
            ResultSrcW  <= ResultSrcM;
            RDW         <= RDM;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= w_rdata_ext;
            PCPlus4W    <= PCPlus4M;
`ifdef MEM_MISALIGN_TRAP_EN
            MisalignW   <= w_misalign;
`endif
        end else begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            MisalignW   <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_cycle.sv
// Bench for mem_access_cycle: table of MEM-stage operations driven against a
// small bus responder, W-stage results checked through a scoreboard queue,
// plus a hand-written reset-during-load sequence.
module tb_mem_access_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RDM;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM, ValidW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RDW;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    always #5 clk = ~clk;

    mem_access_cycle #(.XLEN(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .funct3M     (funct3M),
        .RDM         (RDM),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .StallM      (StallM),
        .ValidW      (ValidW),
`ifdef MEM_MISALIGN_TRAP_EN
        .MisalignW   (MisalignW),
`endif
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RDW         (RDW),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W)
    );

    typedef struct {
        logic        valid, regw, memw;
        logic [1:0]  rsrc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr, wdata, pc4, rdata;
        int          gnt_dly, rv_dly;
        bit          stray, from_mem;
        bit          exp_bus;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rdw;
        bit          chk_rd;
        int          exp_stall;
        bit          exp_mis;
    } vec_t;

    typedef struct {
        logic        regw;
        logic [4:0]  rd;
        logic [1:0]  rsrc;
        logic [31:0] alu, pc4, rdw;
        bit          chk_rd, mis;
    } exp_w_t;

    localparam int NV = 15;
    vec_t        vecs [NV];
    exp_w_t      sb_q [$];
    logic [31:0] mem_model [logic [29:0]];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic regw, input logic memw,
                                input logic [1:0] rsrc, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                                input int gd, input int rvd, input bit stray, input bit from_mem,
                                input bit exp_bus, input logic [3:0] be, input logic [31:0] ew,
                                input logic [31:0] erdw, input bit chk, input int est, input bit mis);
        vec_t v;
        v.valid = valid; v.regw = regw; v.memw = memw; v.rsrc = rsrc; v.f3 = f3; v.rd = rd;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.pc4 = 32'h0000_1000 + 32'(rd) * 4;
        v.gnt_dly = gd; v.rv_dly = rvd; v.stray = stray; v.from_mem = from_mem;
        v.exp_bus = exp_bus; v.exp_be = be; v.exp_wdata = ew; v.exp_rdw = erdw;
        v.chk_rd = chk; v.exp_stall = est; v.exp_mis = mis;
        return v;
    endfunction

    // Scoreboard: every W slot with ValidW must match the oldest pushed entry.
    always @(negedge clk) begin
        exp_w_t e;
        if (rst && ValidW) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL w_unexpected: got ValidW=1 rd=%0d expected no retirement", RDW);
            end else begin
                e = sb_q.pop_front();
                check1("RegWriteW", RegWriteW, e.regw);
                check("RDW", {27'b0, RDW}, {27'b0, e.rd});
                check("ResultSrcW", {30'b0, ResultSrcW}, {30'b0, e.rsrc});
                check("ALU_ResultW", ALU_ResultW, e.alu);
                check("PCPlus4W", PCPlus4W, e.pc4);
                if (e.chk_rd) check("ReadDataW", ReadDataW, e.rdw);
`ifdef MEM_MISALIGN_TRAP_EN
                check1("MisalignW", MisalignW, e.mis);
`endif
            end
        end
    end

    // Drive one M-stage op and act as the memory until the stage releases it.
    task automatic run_vec(input vec_t v, input int idx);
        int          req_cyc = 0;
        int          stall_cyc = 0;
        int          since = -1;
        int          guard = 0;
        bit          done = 0;
        logic [31:0] rd_word;
        logic [31:0] mw;
        exp_w_t      e;
        ValidM = v.valid; RegWriteM = v.regw; MemWriteM = v.memw; ResultSrcM = v.rsrc;
        funct3M = v.f3; RDM = v.rd; ALU_ResultM = v.addr; WriteDataM = v.wdata; PCPlus4M = v.pc4;
        rd_word = (v.from_mem && mem_model.exists(v.addr[31:2])) ? mem_model[v.addr[31:2]] : v.rdata;
        if (v.valid) begin
            e.regw = v.regw & ~v.exp_mis; e.rd = v.rd; e.rsrc = v.rsrc; e.alu = v.addr;
            e.pc4 = v.pc4; e.rdw = v.exp_rdw; e.chk_rd = v.chk_rd; e.mis = v.exp_mis;
            sb_q.push_back(e);
        end
        while (!done && guard < 40) begin
            guard++;
            if (since >= 0) since++;
            dmem_gnt    = 1'b0;
            dmem_rvalid = (since > 0) && (since == v.rv_dly);
            dmem_rdata  = rd_word;
            #1;
            if (dmem_req) begin
                check($sformatf("v%0d_addr", idx), dmem_addr, {v.addr[31:2], 2'b00});
                check1($sformatf("v%0d_we", idx), dmem_we, v.memw);
                if (v.memw) begin
                    check($sformatf("v%0d_be", idx), {28'b0, dmem_be}, {28'b0, v.exp_be});
                    check($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
                end
                if (req_cyc == v.gnt_dly) begin
                    dmem_gnt = 1'b1;
                    since = 0;
                    if (v.stray) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = ~rd_word;
                    end
                end
                req_cyc++;
            end
            #1;
            if (StallM) stall_cyc++;
            else        done = 1;
            if (v.memw && dmem_req && dmem_gnt) begin
                mw = mem_model.exists(dmem_addr[31:2]) ? mem_model[dmem_addr[31:2]] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (dmem_be[b]) mw[b*8 +: 8] = dmem_wdata[b*8 +: 8];
                mem_model[dmem_addr[31:2]] = mw;
            end
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL v%0d_timeout: got StallM stuck for %0d cycles expected release", idx, guard);
        end
        check($sformatf("v%0d_stall_cycles", idx), 32'(stall_cyc), 32'(v.exp_stall));
        check($sformatf("v%0d_req_cycles", idx), 32'(req_cyc), v.exp_bus ? 32'(v.gnt_dly + 1) : 32'd0);
        $display("txn v%0d valid=%0d we=%0d f3=%0d addr=0x%08h stall=%0d req_cycles=%0d",
                 idx, v.valid, v.memw, v.f3, v.addr, stall_cyc, req_cyc);
    endtask

    task automatic drive_idle();
        ValidM = 0; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 2'b00; funct3M = 3'b000;
        RDM = 0; ALU_ResultM = 0; WriteDataM = 0; PCPlus4M = 0;
    endtask

    task automatic check_w_zero(input string tag);
        check1({tag, "_ValidW"}, ValidW, 1'b0);
        check1({tag, "_RegWriteW"}, RegWriteW, 1'b0);
        check({tag, "_RDW"}, {27'b0, RDW}, 32'h0);
        check({tag, "_ALU_ResultW"}, ALU_ResultW, 32'h0);
        check({tag, "_ReadDataW"}, ReadDataW, 32'h0);
        check({tag, "_PCPlus4W"}, PCPlus4W, 32'h0);
        check({tag, "_ResultSrcW"}, {30'b0, ResultSrcW}, 32'h0);
        check1({tag, "_req"}, dmem_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v  rw mw rsrc   f3      rd  addr          wdata         rdata         gd rv st fm bus be       ewdata        erdw          chk st mis
        vecs[0]  = mk(1, 1, 0, 2'b01, 3'b000, 5,  32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF_FF80, 1, 1, 0);
        vecs[1]  = mk(1, 0, 1, 2'b00, 3'b001, 0,  32'h0000_0102, 32'h1234_ABCD, 32'h0,        3, 0, 0, 0, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 3, 0);
        vecs[2]  = mk(1, 1, 0, 2'b01, 3'b101, 6,  32'h0000_0002, 32'h0,        32'hBEEF_0000, 0, 6, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_BEEF, 1, 6, 0);
        vecs[3]  = mk(1, 0, 1, 2'b00, 3'b010, 0,  32'h0000_0200, 32'hCAFE_F00D, 32'h0,        1, 0, 0, 0, 1, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 1, 0);
        vecs[4]  = mk(1, 1, 0, 2'b01, 3'b010, 7,  32'h0000_0200, 32'h0,        32'h0,        0, 1, 0, 1, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 1, 1, 0);
        vecs[5]  = mk(1, 1, 0, 2'b00, 3'b000, 8,  32'h1234_5678, 32'h0,        32'h0,        0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 2'b00, 3'b010, 0,  32'h0000_0300, 32'hFFFF_FFFF, 32'h0,        0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0);
        vecs[7]  = mk(1, 0, 1, 2'b00, 3'b000, 0,  32'h0000_0001, 32'h0000_0077, 32'h0,        0, 0, 0, 0, 1, 4'b0010, 32'h7777_7777, 32'h0,        0, 0, 0);
        vecs[8]  = mk(1, 1, 0, 2'b01, 3'b001, 10, 32'h0000_0002, 32'h0,        32'h8001_0000, 0, 1, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF_8001, 1, 1, 0);
        vecs[9]  = mk(1, 1, 0, 2'b01, 3'b100, 11, 32'h0000_0001, 32'h0,        32'h0000_9A00, 0, 1, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_009A, 1, 1, 0);
        vecs[10] = mk(1, 1, 0, 2'b10, 3'b000, 1,  32'h0000_0040, 32'h0,        32'h0,        0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0);
        vecs[11] = mk(1, 1, 0, 2'b01, 3'b010, 12, 32'h0000_0300, 32'h0,        32'h1122_3344, 1, 2, 1, 0, 1, 4'b0000, 32'h0,        32'h1122_3344, 1, 3, 0);
        vecs[12] = mk(1, 1, 0, 2'b01, 3'b011, 13, 32'h0000_0004, 32'h0,        32'h55AA_55AA, 0, 1, 0, 0, 1, 4'b0000, 32'h0,        32'h55AA_55AA, 1, 1, 0);
        vecs[13] = mk(1, 0, 1, 2'b00, 3'b000, 0,  32'h0000_0003, 32'h0000_00A5, 32'h0,        0, 0, 0, 0, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[14] = mk(1, 1, 0, 2'b01, 3'b010, 14, 32'h0000_0101, 32'h0,        32'hDEAD_BEEF, 0, 1, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 1);
`else
        vecs[14] = mk(1, 1, 0, 2'b01, 3'b010, 14, 32'h0000_0101, 32'h0,        32'hDEAD_BEEF, 0, 1, 0, 0, 1, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1, 1, 0);
`endif

        rst = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_w_zero("reset");

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset while a granted load waits for its data.
        ValidM = 1; RegWriteM = 1; MemWriteM = 0; ResultSrcM = 2'b01; funct3M = 3'b010;
        RDM = 9; ALU_ResultM = 32'h0000_0400; WriteDataM = 0; PCPlus4M = 32'h0000_2000;
        #1;
        check1("rstseq_req", dmem_req, 1'b1);
        dmem_gnt = 1'b1;
        #1;
        check1("rstseq_stall_gnt", StallM, 1'b1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        #1;
        check1("rstseq_stall_resp", StallM, 1'b1);
        check1("rstseq_req_resp", dmem_req, 1'b0);
        rst = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        check_w_zero("rstseq");
        check1("rstseq_stall_after", StallM, 1'b0);
        $display("txn reset_in_resp rd=9 addr=0x00000400");
        dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check1("rstseq_stray_ValidW", ValidW, 1'b0);
        check1("rstseq_stray_req", dmem_req, 1'b0);
        $display("txn stray_rvalid ignored");
        run_vec(vecs[5], 100);
        run_vec(vecs[0], 101);

        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
